// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions: opcodes, branch funct3 codes and immediate formats.
package rv_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    typedef enum logic [2:0] {ImmNone, ImmI, ImmS, ImmB, ImmU, ImmJ} imm_type_e;

    function automatic imm_type_e imm_type_of(logic [6:0] op);
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: return ImmI;
            OP_STORE:                 return ImmS;
            OP_BRANCH:                return ImmB;
            OP_LUI, OP_AUIPC:         return ImmU;
            OP_JAL:                   return ImmJ;
            default:                  return ImmNone;
        endcase
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read one-write register file with optional same-cycle write-back forwarding.
module regfile_2r1w
    import rv_pkg::*;
#(
    parameter int unsigned      NREGS    = 32,
    parameter int unsigned      XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  SP_RESET = 32'h0001_0000,
    parameter bit               BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0] regs_q [NREGS];

    // Entry 0 is reset to zero and never written, so x0 reads as 0 through the array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == 2) ? SP_RESET : '0;
            end
        end else if (wb_en && wb_rd != 5'd0 && 32'(wb_rd) < NREGS) begin
            regs_q[wb_rd[AW-1:0]] <= wb_data;
        end
    end

    function automatic logic [XLEN-1:0] read_port(logic [4:0] idx);
        if (BYPASS && wb_en && wb_rd == idx && idx != 5'd0) begin
            return wb_data;
        end else if (32'(idx) < NREGS) begin
            return regs_q[idx[AW-1:0]];
        end
        return '0;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1);
        rs2_data = read_port(rs2);
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I/RV32E decode stage: operand read, immediate generation, branch resolution and a
// valid/ready output register whose held operands track write-backs.
module decode_stage
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter int unsigned     NREGS    = 32,
    parameter logic [XLEN-1:0] SP_RESET = 32'h0001_0000,
    parameter bit              BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7_5,
    output logic            out_br_taken,
    output logic            out_illegal
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [4:0]        rs1, rs2, rd;
    logic [XLEN-1:0]   rs1_data, rs2_data, imm, hold_rs1_data, hold_rs2_data;
    logic signed [31:0] imm32;
    logic              known, use_rs1, use_rs2, use_rd, illegal, taken, hold_taken, accept;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    regfile_2r1w #(
        .NREGS    (NREGS),
        .XLEN     (XLEN),
        .SP_RESET (SP_RESET),
        .BYPASS   (BYPASS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    function automatic logic br_cmp(logic [2:0] f3, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        case (f3)
            F3_BEQ:  return a == b;
            F3_BNE:  return a != b;
            F3_BLT:  return $signed(a) < $signed(b);
            F3_BGE:  return $signed(a) >= $signed(b);
            F3_BLTU: return a < b;
            F3_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        imm32 = '0;
        case (imm_type_of(opcode))
            ImmI:    imm32 = {{20{inst[31]}}, inst[31:20]};
            ImmS:    imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            ImmB:    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            ImmU:    imm32 = {inst[31:12], 12'b0};
            ImmJ:    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'(imm32);

    // Only register fields the format actually uses count toward the index-range check.
    always_comb begin
        known   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OP_OP:                                       {use_rs1, use_rs2, use_rd} = 3'b111;
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: {use_rs1, use_rd} = 2'b11;
            OP_STORE, OP_BRANCH:                         {use_rs1, use_rs2} = 2'b11;
            OP_LUI, OP_AUIPC, OP_JAL:                    use_rd = 1'b1;
            default:                                     known = 1'b0;
        endcase
    end

    assign illegal = !known
                   || (use_rs1 && 32'(rs1) >= NREGS)
                   || (use_rs2 && 32'(rs2) >= NREGS)
                   || (use_rd && 32'(rd) >= NREGS)
                   || (opcode == OP_BRANCH && (funct3 == 3'd2 || funct3 == 3'd3));
    assign taken = (opcode == OP_BRANCH) && !illegal && br_cmp(funct3, rs1_data, rs2_data);

    // Operands of a stalled bundle follow write-backs so execute never sees stale data.
    always_comb begin
        hold_rs1_data = out_rs1_data;
        hold_rs2_data = out_rs2_data;
        if (wb_en && wb_rd == out_rs1 && out_rs1 != 5'd0) hold_rs1_data = wb_data;
        if (wb_en && wb_rd == out_rs2 && out_rs2 != 5'd0) hold_rs2_data = wb_data;
        hold_taken = (out_opcode == OP_BRANCH) && !out_illegal
                   && br_cmp(out_funct3, hold_rs1_data, hold_rs2_data);
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_rs1      <= '0;
            out_rs2      <= '0;
            out_rd       <= '0;
            out_imm      <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7_5 <= 1'b0;
            out_br_taken <= 1'b0;
            out_illegal  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= pc;
            out_rs1_data <= rs1_data;
            out_rs2_data <= rs2_data;
            out_rs1      <= rs1;
            out_rs2      <= rs2;
            out_rd       <= rd;
            out_imm      <= imm;
            out_opcode   <= opcode;
            out_funct3   <= funct3;
            out_funct7_5 <= inst[30];
            out_br_taken <= taken;
            out_illegal  <= illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            out_rs1_data <= hold_rs1_data;
            out_rs2_data <= hold_rs2_data;
            out_br_taken <= hold_taken;
        end
    end

endmodule
